disp_mode_ctrl: RTL

Parametrised successor of the stopwatch/calculator top-level mode and display controller. Arbitrates between STOPWATCH and CALC modes from keypad events and issues stopwatch run/hold/clear commands. Converts the selected binary values into per-digit BCD codes with one time-shared sequential double-dabble engine. Drives the main digit bank and the two operand digit banks. Sits between keypad/read_cal/stopwatch/calculator and the per-digit 7-segment decoders.

---
 rtl/disp_pkg.sv | 45 ++++
 rtl/bin2bcd_seq.sv | 57 +++++
 rtl/disp_mode_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants, encodings and sizing helpers for the display/mode controller.
package disp_pkg;

  // Digit codes understood by the downstream 7-segment decoders
  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;
  localparam logic [3:0] DIG_ERR   = 4'd14;

  // Keypad function codes (0-9 are numeric keys and are not used here)
  localparam logic [3:0] KEY_CLR  = 4'd10;
  localparam logic [3:0] KEY_CAP  = 4'd11;
  localparam logic [3:0] KEY_HOLD = 4'd12;
  localparam logic [3:0] KEY_RUN  = 4'd13;
  localparam logic [3:0] KEY_ADD  = 4'd14;
  localparam logic [3:0] KEY_SUB  = 4'd15;

  // Stopwatch command encodings
  localparam logic [1:0] SW_RUN   = 2'd0;
  localparam logic [1:0] SW_HOLD  = 2'd1;
  localparam logic [1:0] SW_CLEAR = 2'd2;

  typedef enum logic {
    MODE_SW   = 1'b0,
    MODE_CALC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_LOAD,
    CV_SHIFT,
    CV_COMMIT
  } cv_state_e;

  typedef enum logic [1:0] {
    SRC_MAIN,
    SRC_OPA,
    SRC_OPB
  } src_e;

  // BCD nibbles needed for a w-bit binary value: ceil(w*log10(2)) plus one spare
  function automatic int bcd_nibbles(input int w);
    return (w * 302 + 999) / 1000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle after start.
module bin2bcd_seq #(
  parameter int VAL_W = 32,
  parameter int NIB   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VAL_W-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [4*NIB-1:0]   bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [VAL_W-1:0] sr;
  logic [4*NIB-1:0] adj;

  // done marks the cycle of the final shift so the caller can commit next cycle
  assign done = busy && (cnt == CNT_W'(1));

  // Add-3 correction on every nibble that would reach 10 or more after doubling
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NIB; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Bit counter and busy flag; a start always restarts a fresh conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(VAL_W);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // Shift datapath: accumulator takes the binary MSB each cycle
  always_ff @(posedge clk) begin
    if (start) begin
      sr  <= din;
      bcd <= '0;
    end else if (busy) begin
      sr  <= sr << 1;
      bcd <= (adj << 1) | {{(4*NIB-1){1'b0}}, sr[VAL_W-1]};
    end
  end

endmodule

// File: rtl/disp_mode_ctrl.sv
// Top-level mode arbitration and time-shared BCD display refresh.
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int OPD_DIGITS = 2,
  parameter int VAL_W      = 32,
  parameter int LZB        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  input  logic [VAL_W-1:0]        sw_count,
  input  logic [VAL_W-1:0]        calc_ans,
  input  logic                    calc_neg,
  input  logic [VAL_W-1:0]        opd_a,
  input  logic [VAL_W-1:0]        opd_b,
  output logic [1:0]              sw_cmd,
  output logic                    mode,
  output logic [4*DIGITS-1:0]     main_dig,
  output logic [4*OPD_DIGITS-1:0] opa_dig,
  output logic [4*OPD_DIGITS-1:0] opb_dig,
  output logic                    ovf,
  output logic                    upd
);

  // Accumulator width; assumed to cover at least DIGITS and OPD_DIGITS nibbles
  localparam int NIB = bcd_nibbles(VAL_W);

  mode_e            mode_q, mode_d;
  logic [1:0]       sw_cmd_q, sw_cmd_d;
  logic [VAL_W-1:0] cap_q, cap_d;

  cv_state_e        st_q, st_d;
  src_e             src_q;
  logic             start;
  logic [VAL_W-1:0] src_val;
  logic             src_neg;
  logic             neg_p0;
  logic             busy, done;
  logic [4*NIB-1:0] bcd_p1;
  logic [4*DIGITS:0]       main_res;
  logic [4*OPD_DIGITS-1:0] opd_res;

  // Main bank formatting: sign, overflow detection, optional zero blanking.
  // Returns {ovf, digits}. Overflow is any nonzero nibble above the field.
  function automatic logic [4*DIGITS:0] fmt_main(input logic [4*NIB-1:0] b,
                                                 input logic neg);
    logic [4*DIGITS-1:0] d;
    logic                o;
    logic                lead;
    int                  mag_n;
    mag_n = neg ? DIGITS - 1 : DIGITS;
    o = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (i >= mag_n && b[4*i +: 4] != 4'd0) o = 1'b1;
    end
    d = b[4*DIGITS-1:0];
    if (neg) d[4*(DIGITS-1) +: 4] = DIG_MINUS;
    if (LZB != 0) begin
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (i < mag_n) begin
          if (lead && d[4*i +: 4] == 4'd0) d[4*i +: 4] = DIG_BLANK;
          else lead = 1'b0;
        end
      end
    end
    if (o) d = {DIGITS{DIG_ERR}};
    return {o, d};
  endfunction

  // Operand banks show the truncated low digits only while in CALC
  function automatic logic [4*OPD_DIGITS-1:0] fmt_opd(input logic [4*NIB-1:0] b,
                                                      input mode_e m);
    if (m == MODE_CALC) return b[4*OPD_DIGITS-1:0];
    return {OPD_DIGITS{DIG_BLANK}};
  endfunction

  assign mode   = mode_q;
  assign sw_cmd = sw_cmd_q;

  // Mode / stopwatch-command next state from keypad events
  always_comb begin
    mode_d   = mode_q;
    sw_cmd_d = sw_cmd_q;
    cap_d    = cap_q;
    if (key_valid) begin
      if (mode_q == MODE_SW) begin
        case (key_code)
          KEY_CAP: begin
            sw_cmd_d = SW_HOLD;
            cap_d    = sw_count;
          end
          KEY_CLR: begin
            sw_cmd_d = SW_CLEAR;
            cap_d    = '0;
          end
          KEY_HOLD: sw_cmd_d = SW_HOLD;
          KEY_RUN:  sw_cmd_d = SW_RUN;
          KEY_ADD, KEY_SUB: mode_d = MODE_CALC;
          default: ;
        endcase
      end else if (key_code == KEY_RUN) begin
        mode_d = MODE_SW;
      end
    end
  end

  // Mode, command and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_SW;
      sw_cmd_q <= SW_HOLD;
      cap_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      sw_cmd_q <= sw_cmd_d;
      cap_q    <= cap_d;
    end
  end

  // Source selection for the converter; only MAIN in CALC carries a sign
  always_comb begin
    src_val = cap_q;
    src_neg = 1'b0;
    case (src_q)
      SRC_MAIN: begin
        if (mode_q == MODE_CALC) begin
          src_val = calc_ans;
          src_neg = calc_neg;
        end
      end
      SRC_OPA: src_val = opd_a;
      default: src_val = opd_b;
    endcase
  end

  // Converter sequencing: LOAD, VAL_W shift cycles, COMMIT, then next source
  always_comb begin
    st_d  = st_q;
    start = 1'b0;
    case (st_q)
      CV_IDLE: st_d = CV_LOAD;
      CV_LOAD: begin
        start = 1'b1;
        st_d  = CV_SHIFT;
      end
      CV_SHIFT: begin
        if (done)       st_d = CV_COMMIT;
        else if (!busy) st_d = CV_LOAD;
      end
      CV_COMMIT: st_d = CV_LOAD;
      default:   st_d = CV_IDLE;
    endcase
  end

  // ---- stage p0: sign snapshot taken with the value at LOAD ----
  always_ff @(posedge clk) begin
    if (st_q == CV_LOAD) neg_p0 <= src_neg;
  end

  // ---- stage p1: serial BCD conversion ----
  bin2bcd_seq #(
    .VAL_W (VAL_W),
    .NIB   (NIB)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (src_val),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd_p1)
  );

  assign main_res = fmt_main(bcd_p1, neg_p0);
  assign opd_res  = fmt_opd(bcd_p1, mode_q);

  // ---- stage p2: atomic bank commit and round-robin advance ----
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= CV_IDLE;
      src_q    <= SRC_MAIN;
      main_dig <= {DIGITS{DIG_BLANK}};
      opa_dig  <= {OPD_DIGITS{DIG_BLANK}};
      opb_dig  <= {OPD_DIGITS{DIG_BLANK}};
      ovf      <= 1'b0;
      upd      <= 1'b0;
    end else begin
      st_q <= st_d;
      upd  <= 1'b0;
      if (st_q == CV_COMMIT) begin
        case (src_q)
          SRC_MAIN: begin
            main_dig <= main_res[4*DIGITS-1:0];
            ovf      <= main_res[4*DIGITS];
            upd      <= 1'b1;
            src_q    <= SRC_OPA;
          end
          SRC_OPA: begin
            opa_dig <= opd_res;
            src_q   <= SRC_OPB;
          end
          default: begin
            opb_dig <= opd_res;
            src_q   <= SRC_MAIN;
          end
        endcase
      end
    end
  end

endmodule
